tff_counter: RTL and testbench

Parametrised synchronous counter/toggle register built from T-flip-flop cells. It generalises the single-bit toggle flip-flop into a WIDTH-bit register with four operating modes: per-bit toggle, count up, count down and parallel load. It also provides a programmable modulus, optional saturation, terminal-count and wrap indications, and a defined priority between clear and preset. It is the standard counting/divider primitive for timers, clock dividers and sequencers in the design.

---
 rtl/tff_counter.sv | 146 ++++++++++++++
 tb/tb_tff_counter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tff_counter.sv
// ---------------------------------------------------------------------------
// tff_counter
//
// WIDTH-bit counter/toggle register built from T-flip-flop cells. It has four
// operating modes (per-bit toggle, count up, count down, parallel load), a
// programmable modulus, optional saturation, terminal-count and wrap
// indications, and a fixed priority of clr > pre > enabled operation > hold.
//
// Parameters:
//   WIDTH     register width in bits (1..32)
//   MODULO    count range 0..MODULO-1, 2 <= MODULO <= 2**WIDTH
//   SATURATE  0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-high clear, q <= 0 (wins over pre)
//   pre        synchronous active-high preset, q <= MODULO-1
//   en         operation enable; q holds when low
//   mode       00 toggle, 01 up, 10 down, 11 load
//   t          per-bit toggle mask (mode 00)
//   d          parallel load data (mode 11)
//   q          registered count/state
//   qn         bitwise complement of q
//   tc         terminal count (combinational), for cascading stages
//   wrap       one-cycle pulse in the cycle q shows a wrapped value
//   range_err  one-cycle pulse in the cycle q shows a clamped toggle/load
// ---------------------------------------------------------------------------
module tff_counter #(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULO   = 64'd1 << WIDTH,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             wrap,
    output logic             range_err
);

    // Largest legal count. MODULO may be 2**WIDTH, which does not fit in
    // WIDTH bits, so every range comparison is made against MODULO-1 instead.
    localparam longint unsigned MAX_L   = MODULO - 64'd1;
    localparam logic [WIDTH-1:0] MAX_VAL = MAX_L[WIDTH-1:0];

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_LOAD   = 2'b11;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             range_err_q, range_err_d;

    logic [WIDTH-1:0] toggled;
    logic             at_max;
    logic             at_zero;

    // One T-flip-flop cell per bit: a set mask bit inverts that bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tcell
        assign toggled[gi] = count_q[gi] ^ t[gi];
    end

    assign at_max  = (count_q == MAX_VAL);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d     = count_q;
        wrap_d      = 1'b0;
        range_err_d = 1'b0;

        if (clr) begin
            count_d = '0;
        end else if (pre) begin
            count_d = MAX_VAL;
        end else if (en) begin
            case (mode)
                MODE_TOGGLE: begin
                    if (toggled > MAX_VAL) begin
                        count_d     = MAX_VAL;
                        range_err_d = 1'b1;
                    end else begin
                        count_d = toggled;
                    end
                end
                MODE_UP: begin
                    // Explicit compare, never natural overflow, so a short
                    // modulus wraps at MODULO-1 rather than at 2**WIDTH-1.
                    if (!at_max) begin
                        count_d = count_q + WIDTH'(1);
                    end else if (!SATURATE) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end
                MODE_DOWN: begin
                    if (!at_zero) begin
                        count_d = count_q - WIDTH'(1);
                    end else if (!SATURATE) begin
                        count_d = MAX_VAL;
                        wrap_d  = 1'b1;
                    end
                end
                MODE_LOAD: begin
                    if (d > MAX_VAL) begin
                        count_d     = MAX_VAL;
                        range_err_d = 1'b1;
                    end else begin
                        count_d = d;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q     <= '0;
            wrap_q      <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wrap_q      <= wrap_d;
            range_err_q <= range_err_d;
        end
    end

    assign q         = count_q;
    assign qn        = ~count_q;
    assign wrap      = wrap_q;
    assign range_err = range_err_q;

    // Asserted the cycle before a wrap/saturation edge, regardless of
    // SATURATE, so tc can enable a following counter stage.
    assign tc = en & (((mode == MODE_UP) & at_max) | ((mode == MODE_DOWN) & at_zero));

endmodule

// File: tb/tb_tff_counter.sv
// ---------------------------------------------------------------------------
// tb_tff_counter
//
// Three counter instances share the control inputs:
//   ua : defaults (WIDTH=8, MODULO=256, SATURATE=0)
//   ub : WIDTH=4, MODULO=10, SATURATE=0
//   uc : WIDTH=4, MODULO=10, SATURATE=1
// Directed scenarios check fixed expected values; a randomized run compares
// all three against an arithmetic reference model of the counting rules.
// ---------------------------------------------------------------------------
module tb_tff_counter;

    logic       clk = 1'b0;
    logic       clr, pre, en;
    logic [1:0] mode;
    logic [7:0] t8, d8;
    logic [3:0] t4, d4;

    logic [7:0] qa, qna;
    logic [3:0] qb, qnb, qc, qnc;
    logic       tca, tcb, tcc, wa, wb, wc, ea, eb, ec;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tff_counter u_a (
        .clk(clk), .clr(clr), .pre(pre), .en(en), .mode(mode), .t(t8), .d(d8),
        .q(qa), .qn(qna), .tc(tca), .wrap(wa), .range_err(ea)
    );

    tff_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u_b (
        .clk(clk), .clr(clr), .pre(pre), .en(en), .mode(mode), .t(t4), .d(d4),
        .q(qb), .qn(qnb), .tc(tcb), .wrap(wb), .range_err(eb)
    );

    tff_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1)) u_c (
        .clk(clk), .clr(clr), .pre(pre), .en(en), .mode(mode), .t(t4), .d(d4),
        .q(qc), .qn(qnc), .tc(tcc), .wrap(wc), .range_err(ec)
    );

    // ---------------- reference model (plain integer arithmetic) ----------
    int ma_q = 0, mb_q = 0, mc_q = 0;
    bit ma_w = 0, mb_w = 0, mc_w = 0;
    bit ma_e = 0, mb_e = 0, mc_e = 0;

    function automatic void model_step(input int q, input int m, input bit sat,
                                       input int tv, input int dv,
                                       output int nq, output bit w, output bit e);
        int nxt;
        nq = q;
        w  = 1'b0;
        e  = 1'b0;
        if (clr) begin
            nq = 0;
        end else if (pre) begin
            nq = m - 1;
        end else if (en) begin
            case (mode)
                2'd0, 2'd3: begin
                    nxt = (mode == 2'd0) ? (q ^ tv) : dv;
                    if (nxt >= m) begin
                        nq = m - 1;
                        e  = 1'b1;
                    end else begin
                        nq = nxt;
                    end
                end
                2'd1: begin
                    if (q < m - 1) nq = q + 1;
                    else if (!sat) begin nq = 0; w = 1'b1; end
                end
                default: begin
                    if (q > 0) nq = q - 1;
                    else if (!sat) begin nq = m - 1; w = 1'b1; end
                end
            endcase
        end
    endfunction

    function automatic bit model_tc(input int q, input int m);
        return en && ((mode == 2'd1 && q == m - 1) || (mode == 2'd2 && q == 0));
    endfunction

    always @(posedge clk) begin
        int nq;
        bit w, e;
        model_step(ma_q, 256, 1'b0, int'(t8), int'(d8), nq, w, e);
        ma_q <= nq; ma_w <= w; ma_e <= e;
        model_step(mb_q, 10, 1'b0, int'(t4), int'(d4), nq, w, e);
        mb_q <= nq; mb_w <= w; mb_e <= e;
        model_step(mc_q, 10, 1'b1, int'(t4), int'(d4), nq, w, e);
        mc_q <= nq; mc_w <= w; mc_e <= e;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clr = 1'b1; pre = 1'b1; en = 1'b1; mode = 2'b01;
        t8 = '0; d8 = '0; t4 = '0; d4 = '0;
        tick();
        vectors++;
        if (qa !== 8'h00) begin miscompares++; $display("FAIL reset_q: got %0h expected 0", qa); end
        vectors++;
        if (qna !== 8'hFF) begin miscompares++; $display("FAIL reset_qn: got %0h expected ff", qna); end
        vectors++;
        if (wa !== 1'b0 || ea !== 1'b0) begin
            miscompares++; $display("FAIL reset_pulses: got wrap=%b err=%b expected 0 0", wa, ea);
        end
        en = 1'b0; #1;
        vectors++;
        if (tca !== 1'b0) begin miscompares++; $display("FAIL reset_tc: got %b expected 0", tca); end
        clr = 1'b0; pre = 1'b1;
        tick();
        vectors++;
        if (qa !== 8'hFF) begin miscompares++; $display("FAIL preset_a: got %0h expected ff", qa); end
        vectors++;
        if (qb !== 4'd9) begin miscompares++; $display("FAIL preset_b: got %0d expected 9", qb); end
        pre = 1'b0;
        $display("reset/preset: qa=%0h qb=%0d", qa, qb);
    endtask

    task automatic test_up_wrap();
        int exp_q;
        clr = 1'b1; tick();
        clr = 1'b0; en = 1'b1; mode = 2'b01;
        exp_q = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            vectors++;
            if (tcb !== (exp_q == 9)) begin
                miscompares++; $display("FAIL up_tc: q=%0d got %b expected %b", qb, tcb, exp_q == 9);
            end
            tick();
            exp_q = (exp_q + 1) % 10;
            vectors++;
            if (qb !== 4'(exp_q)) begin miscompares++; $display("FAIL up_q: got %0d expected %0d", qb, exp_q); end
            vectors++;
            if (wb !== (i == 9)) begin miscompares++; $display("FAIL up_wrap: got %b expected %b", wb, i == 9); end
            $display("up step %0d: q=%0d tc=%b wrap=%b", i, qb, tcb, wb);
        end
    endtask

    task automatic test_down_saturate();
        int exp_seq[4] = '{1, 0, 0, 0};
        mode = 2'b11; d4 = 4'd2; en = 1'b1;
        tick();
        vectors++;
        if (qc !== 4'd2) begin miscompares++; $display("FAIL sat_load: got %0d expected 2", qc); end
        mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (qc !== 4'(exp_seq[i])) begin
                miscompares++; $display("FAIL sat_q: got %0d expected %0d", qc, exp_seq[i]);
            end
            vectors++;
            if (wc !== 1'b0) begin miscompares++; $display("FAIL sat_wrap: got %b expected 0", wc); end
            vectors++;
            if (tcc !== (exp_seq[i] == 0)) begin
                miscompares++; $display("FAIL sat_tc: got %b expected %b", tcc, exp_seq[i] == 0);
            end
            $display("down-sat step %0d: q=%0d tc=%b wrap=%b", i, qc, tcc, wc);
        end
        d4 = 4'd0;
    endtask

    task automatic test_toggle_enable();
        mode = 2'b11; d8 = 8'h0F; en = 1'b1;
        tick();
        mode = 2'b00; t8 = 8'hF0;
        tick();
        vectors++;
        if (qa !== 8'hFF) begin miscompares++; $display("FAIL toggle1: got %0h expected ff", qa); end
        t8 = 8'h81;
        tick();
        vectors++;
        if (qa !== 8'h7E) begin miscompares++; $display("FAIL toggle2: got %0h expected 7e", qa); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (qa !== 8'h7E || tca !== 1'b0) begin
                miscompares++; $display("FAIL hold: got q=%0h tc=%b expected 7e 0", qa, tca);
            end
            $display("hold step %0d: q=%0h", i, qa);
        end
        t8 = 8'h00; d8 = 8'h00;
    endtask

    task automatic test_range_clamp();
        en = 1'b1; mode = 2'b11; d4 = 4'hC;
        tick();
        vectors++;
        if (qb !== 4'd9 || eb !== 1'b1) begin
            miscompares++; $display("FAIL clamp: got q=%0d err=%b expected 9 1", qb, eb);
        end
        d4 = 4'd3;
        tick();
        vectors++;
        if (qb !== 4'd3 || eb !== 1'b0) begin
            miscompares++; $display("FAIL load_ok: got q=%0d err=%b expected 3 0", qb, eb);
        end
        $display("range: q=%0d err=%b", qb, eb);
        d4 = 4'd0;
    endtask

    task automatic test_mid_reset();
        clr = 1'b1; tick();
        clr = 1'b0; en = 1'b1; mode = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (qna !== ~qa) begin miscompares++; $display("FAIL qn_up: got %0h expected %0h", qna, ~qa); end
        end
        vectors++;
        if (qa !== 8'd5) begin miscompares++; $display("FAIL count5: got %0d expected 5", qa); end
        clr = 1'b1;
        tick();
        vectors++;
        if (qa !== 8'd0 || qna !== 8'hFF) begin
            miscompares++; $display("FAIL mid_clr: got q=%0h qn=%0h expected 0 ff", qa, qna);
        end
        clr = 1'b0;
        tick();
        vectors++;
        if (qa !== 8'd1 || qna !== 8'hFE) begin
            miscompares++; $display("FAIL resume: got q=%0h qn=%0h expected 1 fe", qa, qna);
        end
        $display("mid-reset: q=%0d qn=%0h", qa, qna);
    endtask

    task automatic test_random();
        bit ta, tb, tcx;
        for (int i = 0; i < 200; i++) begin
            clr  = ($urandom_range(0, 19) == 0);
            pre  = ($urandom_range(0, 19) == 0);
            en   = ($urandom_range(0, 7) != 0);
            mode = 2'($urandom_range(0, 3));
            t8   = 8'($urandom);
            d8   = 8'($urandom);
            t4   = 4'($urandom);
            d4   = 4'($urandom);
            #1;
            ta  = model_tc(ma_q, 256);
            tb  = model_tc(mb_q, 10);
            tcx = model_tc(mc_q, 10);
            vectors++;
            if (tca !== ta || tcb !== tb || tcc !== tcx) begin
                miscompares++;
                $display("FAIL rnd_tc: got %b%b%b expected %b%b%b", tca, tcb, tcc, ta, tb, tcx);
            end
            tick();
            vectors++;
            if (qa !== 8'(ma_q) || qna !== ~8'(ma_q) || wa !== ma_w || ea !== ma_e) begin
                miscompares++;
                $display("FAIL rnd_a: got q=%0h w=%b e=%b expected q=%0h w=%b e=%b", qa, wa, ea, ma_q, ma_w, ma_e);
            end
            vectors++;
            if (qb !== 4'(mb_q) || qnb !== ~4'(mb_q) || wb !== mb_w || eb !== mb_e) begin
                miscompares++;
                $display("FAIL rnd_b: got q=%0d w=%b e=%b expected q=%0d w=%b e=%b", qb, wb, eb, mb_q, mb_w, mb_e);
            end
            vectors++;
            if (qc !== 4'(mc_q) || qnc !== ~4'(mc_q) || wc !== mc_w || ec !== mc_e) begin
                miscompares++;
                $display("FAIL rnd_c: got q=%0d w=%b e=%b expected q=%0d w=%b e=%b", qc, wc, ec, mc_q, mc_w, mc_e);
            end
            $display("rnd %0d: clr=%b pre=%b en=%b mode=%0d qa=%0h qb=%0d qc=%0d", i, clr, pre, en, mode, qa, qb, qc);
        end
    endtask

    initial begin
        clr = 1'b1; pre = 1'b0; en = 1'b0; mode = 2'b00;
        t8 = '0; d8 = '0; t4 = '0; d4 = '0;
        test_reset();
        test_up_wrap();
        test_down_saturate();
        test_toggle_enable();
        test_range_clamp();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
